// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (port 0,
//   high priority) and the debug/program-loader port (port 1). Each access is
//   sequenced through the memory's fixed read latency and read data is
//   returned to the port that issued the read. The MEM stage derives its stall
//   from p0_req & ~p0_gnt.
//
//   Build option:
//     DMEM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit last winner)
//                     undefined -> fixed priority to port 0, with port 1 forced
//                                  ahead after MAX_WAIT consecutive denials
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pN_req/we/be/addr/wdata     request from port N (held until pN_gnt)
//   pN_gnt                      request accepted this cycle (combinational)
//   pN_rvalid, pN_rdata         one-cycle read return; rdata is 0 otherwise
//   mem_we/be/addr/wd           memory command, driven in the grant cycle
//   mem_rd                      memory read data, LATENCY cycles after issue
//   busy                        a read is outstanding
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LATENCY  = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [DATA_W/8-1:0] p0_be,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [DATA_W/8-1:0] p1_be,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   output logic                p0_gnt,
   output logic                p1_gnt,
   output logic                p0_rvalid,
   output logic                p1_rvalid,
   output logic [DATA_W-1:0]   p0_rdata,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wd,
   input  logic [DATA_W-1:0]   mem_rd,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t     state;
   logic [2:0] rd_cnt;
   logic       owner;      // port that issued the outstanding read
   logic       rd_done;    // rvalid cycle of the outstanding read
   logic       arb_en;
   logic       pick_p1;
   logic       rd_issue;

   assign rd_done = (state == RD_WAIT) && (rd_cnt == 3'd1);

   // Arbitration is open when idle and in the rvalid cycle, so a new access
   // can follow a read back-to-back. Gating with rst_n keeps every grant and
   // memory strobe low for the whole time reset is asserted.
   assign arb_en = rst_n && ((state == IDLE) || rd_done);

`ifdef DMEM_ARB_RR_EN
   logic last_win;   // 1 = port 1 won last, so port 0 wins the next contention

   assign pick_p1 = p1_req && (!p0_req || !last_win);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_win <= 1'b1;
      end else if (p0_gnt || p1_gnt) begin
         last_win <= p1_gnt;
      end
   end
`else
   logic [7:0] wait_cnt;
   logic       starved;

   assign starved = (wait_cnt == 8'(MAX_WAIT));
   assign pick_p1 = p1_req && (!p0_req || starved);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else if (p1_req && !p1_gnt) begin
         if (!starved) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end else begin
         wait_cnt <= 8'd0;
      end
   end
`endif

   assign p1_gnt = arb_en && pick_p1;
   assign p0_gnt = arb_en && p0_req && !pick_p1;

   // Memory command mux; byte enables only matter for writes.
   always_comb begin
      mem_we   = 1'b0;
      mem_be   = '0;
      mem_addr = '0;
      mem_wd   = '0;
      if (p0_gnt) begin
         mem_we   = p0_we;
         mem_be   = p0_we ? p0_be : {BE_W{1'b0}};
         mem_addr = p0_addr;
         mem_wd   = p0_wdata;
      end else if (p1_gnt) begin
         mem_we   = p1_we;
         mem_be   = p1_we ? p1_be : {BE_W{1'b0}};
         mem_addr = p1_addr;
         mem_wd   = p1_wdata;
      end
   end

   assign rd_issue = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);

   // Read sequencing: load the countdown at issue, return data when it hits 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rd_cnt <= 3'd0;
         owner  <= 1'b0;
      end else if (rd_issue) begin
         state  <= RD_WAIT;
         rd_cnt <= 3'(LATENCY);
         owner  <= p1_gnt;
      end else if (state == RD_WAIT) begin
         if (rd_cnt == 3'd1) begin
            state <= IDLE;
         end
         rd_cnt <= rd_cnt - 3'd1;
      end
   end

   assign busy      = (state == RD_WAIT);
   assign p0_rvalid = rd_done && !owner;
   assign p1_rvalid = rd_done && owner;
   assign p0_rdata  = p0_rvalid ? mem_rd : '0;
   assign p1_rdata  = p1_rvalid ? mem_rd : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: pipeline MEM stage, high priority.
  - port 1: debug/program-loader port.
- Sequences each access through the memory's fixed read latency.
- Returns read data to the owning port.
- Sits between the MEM-stage byte-enable/load-extend logic and dmem. Its grant is the MEM-stage stall source (p0_req & ~p0_gnt).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- LATENCY, 1, cycles from address issue to mem_rd valid; legal range 1..4.
- MAX_WAIT, 8, consecutive denied cycles after which port 1 is forced ahead of port 0; legal range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- p0_req / p1_req  in  1  access request; held with its fields stable until gnt
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_be / p1_be  in  DATA_W/8  byte enables (writes only)
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  one-cycle read-data-valid pulse
- p0_rdata / p1_rdata  out  DATA_W  read data; 0 when rvalid is low
- mem_we  out  1  memory write strobe
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data, valid LATENCY cycles after address issue
- busy  out  1  a read is outstanding

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; wait counter 0; owner 0; read countdown 0.
  - All gnt/rvalid/busy/mem_we outputs 0; mem_be, mem_addr, mem_wd and rdata outputs 0.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding, countdown from LATENCY.
- Arbitration:
  - Evaluated combinationally in IDLE, and in the RD_WAIT cycle where the countdown reaches 1 (the rvalid cycle). This allows back-to-back accesses.
  - Port 0 wins when both request, unless the wait counter equals MAX_WAIT; then port 1 wins.
  - At most one gnt per cycle; gnt is never asserted without the matching req.
- Issue in the grant cycle:
  - mem_addr, mem_be, mem_wd are muxed from the winner.
  - mem_we = winner's we.
  - mem_be is forced to 0 for reads.
  - With no grant: mem_we = 0 and mem_be = 0; mem_addr and mem_wd are 0.
- Write: completes in the grant cycle; the next cycle the arbiter is IDLE. No rvalid is generated.
- Read:
  - Owner is registered; countdown is loaded with LATENCY; go to RD_WAIT (busy = 1).
  - Countdown decrements each cycle.
  - When it reaches 1, mem_rd is routed to owner's rdata with owner's rvalid = 1. The next state is IDLE, or RD_WAIT again if a new read is granted in that cycle.
  - LATENCY=1: rvalid is the cycle after the grant, so reads can be issued every cycle.
- Wait counter:
  - Increments when p1_req = 1 and p1_gnt = 0, saturating at MAX_WAIT.
  - Clears on p1_gnt or when p1_req = 0.
- Same port requesting again in its own rvalid cycle: legal, may be granted.
- Request deassertion before gnt: a protocol violation; the request is simply never granted. Request deassertion after gnt has no effect on the outstanding read.
- Reset mid-read: the transaction is dropped and no rvalid is ever issued for it.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Round-robin arbitration with a 1-bit last-winner register, reset value 1, so port 0 wins the first contention.
  - The winner alternates on contention.
  - Wait counter and MAX_WAIT are unused and their logic is not generated.
- Undefined: fixed priority with the starvation override as above.

Test Plan:
- Priority + stall, LATENCY=1: p0 read 0x100 and p1 read 0x200 both requested in cycle 0.
  - cycle 0: p0_gnt = 1, p1_gnt = 0.
  - cycle 1: p0_rvalid = 1 with mem[0x100]; p1_gnt = 1.
  - cycle 2: p1_rvalid = 1 with mem[0x200].
- Write then read, LATENCY=3: p0 write 0xDEADBEEF to 0x40 with be = 4'b1111, then p0 read 0x40.
  - Write granted in cycle 0; read granted in cycle 1; busy = 1 for cycles 2..4.
  - rvalid in cycle 4 with rdata 0xDEADBEEF.
  - A p1 request during cycles 2..3 gets gnt = 0.
- Starvation, MAX_WAIT=4: p0 issues writes every cycle while p1 requests continuously.
  - p1_gnt asserts in cycle 4 while p0_gnt = 0 that cycle; counter reads 0 in cycle 5.
- Byte-enable masking: p1 read with p1_be = 4'hF → mem_be = 0 in the grant cycle. p0 write with be = 4'b0100 → mem_be = 4'b0100.
- Reset mid-read, LATENCY=4: rst_n pulsed low asynchronously 2 cycles after the grant.
  - All outputs are 0 immediately; no rvalid follows; the next request is granted in the first cycle after rst_n rises.
- DMEM_ARB_RR_EN: both ports request reads continuously with LATENCY=1.
  - Grants alternate p0, p1, p0, p1, …; rvalid follows the same alternation one cycle later.
